// File: rtl/lsu_pkg.sv
// Shared load/store path constants: funct3 load codes, load FSM state encodings
// and store byte-enable size codes.
package lsu_pkg;

    localparam logic [2:0] LP_LB  = 3'b000;
    localparam logic [2:0] LP_LH  = 3'b001;
    localparam logic [2:0] LP_LW  = 3'b010;
    localparam logic [2:0] LP_LBU = 3'b100;
    localparam logic [2:0] LP_LHU = 3'b101;

    localparam logic [1:0] LP_IDLE = 2'd0;
    localparam logic [1:0] LP_READ = 2'd1;
    localparam logic [1:0] LP_RESP = 2'd2;

    // Size codes line up with funct3[1:0] so the store path can reuse them directly.
    localparam logic [1:0] LP_STORE_BYTE = 2'b00;
    localparam logic [1:0] LP_STORE_HALF = 2'b01;
    localparam logic [1:0] LP_STORE_WORD = 2'b10;

endpackage

// File: rtl/load_extract.sv
// Combinational lane select and sign/zero extension for loads.
// Macro LOAD_MISALIGN_TRAP_EN: when defined, an LW at a non-zero offset reports an error.
module load_extract
    import lsu_pkg::*;
(
    input  logic [31:0] iword,
    input  logic [1:0]  ioffset,
    input  logic [2:0]  ifunct3,
    output logic [31:0] odata,
    output logic        oerr
);

    logic [31:0] rot;

    // Rotate right by whole bytes, so halves at offset 3 wrap within the word.
    always_comb begin
        rot = iword;
        case (ioffset)
            2'd0: rot = iword;
            2'd1: rot = {iword[7:0],  iword[31:8]};
            2'd2: rot = {iword[15:0], iword[31:16]};
            2'd3: rot = {iword[23:0], iword[31:24]};
            default: rot = iword;
        endcase
    end

    always_comb begin
        odata = '0;
        oerr  = 1'b0;
        case (ifunct3)
            LP_LB:  odata = {{24{rot[7]}}, rot[7:0]};
            LP_LH:  odata = {{16{rot[15]}}, rot[15:0]};
            LP_LBU: odata = {24'd0, rot[7:0]};
            LP_LHU: odata = {16'd0, rot[15:0]};
            LP_LW: begin
`ifdef LOAD_MISALIGN_TRAP_EN
                if (ioffset != 2'd0) begin
                    oerr = 1'b1;
                end else begin
                    odata = rot;
                end
`else
                odata = rot;
`endif
            end
            default: oerr = 1'b1;
        endcase
    end

endmodule

// File: rtl/load_unit.sv
// Load initiator: accepts one request, reads a word, returns a tagged, extended result.
// Macro LOAD_MISALIGN_TRAP_EN (see load_extract) selects misaligned-LW behaviour.
module load_unit
    import lsu_pkg::*;
#(
    parameter int MP_DATA_WIDTH = 32,
    parameter int MP_ADDR_WIDTH = 8,
    parameter int MP_TAG_WIDTH  = 5
) (
    input  logic                     iclk,
    input  logic                     irst,
    input  logic                     ireq_valid,
    output logic                     oreq_ready,
    input  logic [MP_ADDR_WIDTH-1:0] ireq_addr,
    input  logic [2:0]               ireq_funct3,
    input  logic [MP_TAG_WIDTH-1:0]  ireq_tag,
    output logic [MP_ADDR_WIDTH-1:0] omem_addr,
    output logic                     omem_ren,
    input  logic [MP_DATA_WIDTH-1:0] imem_rdata,
    output logic                     orsp_valid,
    input  logic                     irsp_ready,
    output logic [MP_DATA_WIDTH-1:0] orsp_data,
    output logic [MP_TAG_WIDTH-1:0]  orsp_tag,
    output logic                     orsp_err
);

    logic [1:0]               state_q,    state_d;
    logic [1:0]               off_q,      off_d;
    logic [2:0]               funct3_q,   funct3_d;
    logic [MP_TAG_WIDTH-1:0]  tag_q,      tag_d;
    logic [MP_ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic                     mem_ren_q,  mem_ren_d;
    logic                     rsp_valid_q, rsp_valid_d;
    logic [MP_DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic [MP_TAG_WIDTH-1:0]  rsp_tag_q,  rsp_tag_d;
    logic                     rsp_err_q,  rsp_err_d;

    logic                     req_ready;
    logic                     accept;
    logic [MP_DATA_WIDTH-1:0] ext_data;
    logic                     ext_err;

    load_extract u_extract (
        .iword   (imem_rdata),
        .ioffset (off_q),
        .ifunct3 (funct3_q),
        .odata   (ext_data),
        .oerr    (ext_err)
    );

    assign req_ready = !irst && ((state_q == LP_IDLE) ||
                                 ((state_q == LP_RESP) && irsp_ready));
    assign accept    = ireq_valid && req_ready;

    always_comb begin
        state_d     = state_q;
        off_d       = off_q;
        funct3_d    = funct3_q;
        tag_d       = tag_q;
        mem_addr_d  = mem_addr_q;
        mem_ren_d   = mem_ren_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_tag_d   = rsp_tag_q;
        rsp_err_d   = rsp_err_q;

        case (state_q)
            LP_IDLE: begin
                if (accept) begin
                    state_d = LP_READ;
                end
            end
            LP_READ: begin
                state_d     = LP_RESP;
                mem_ren_d   = 1'b0;
                rsp_valid_d = 1'b1;
                rsp_data_d  = ext_data;
                rsp_err_d   = ext_err;
                rsp_tag_d   = tag_q;
            end
            LP_RESP: begin
                if (irsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = accept ? LP_READ : LP_IDLE;
                end
            end
            default: begin
                state_d     = LP_IDLE;
                mem_ren_d   = 1'b0;
                rsp_valid_d = 1'b0;
            end
        endcase

        // Request capture is shared by the IDLE and RESP-retire accept paths.
        if (accept) begin
            off_d      = ireq_addr[1:0];
            funct3_d   = ireq_funct3;
            tag_d      = ireq_tag;
            mem_addr_d = {ireq_addr[MP_ADDR_WIDTH-1:2], 2'b00};
            mem_ren_d  = 1'b1;
        end
    end

    always_ff @(posedge iclk) begin
        if (irst) begin
            state_q     <= LP_IDLE;
            off_q       <= '0;
            funct3_q    <= '0;
            tag_q       <= '0;
            mem_addr_q  <= '0;
            mem_ren_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_tag_q   <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            off_q       <= off_d;
            funct3_q    <= funct3_d;
            tag_q       <= tag_d;
            mem_addr_q  <= mem_addr_d;
            mem_ren_q   <= mem_ren_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_tag_q   <= rsp_tag_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign oreq_ready = req_ready;
    assign omem_addr  = mem_addr_q;
    assign omem_ren   = mem_ren_q;
    assign orsp_valid = rsp_valid_q;
    assign orsp_data  = rsp_data_q;
    assign orsp_tag   = rsp_tag_q;
    assign orsp_err   = rsp_err_q;

endmodule

// File: tb/tb_load_unit.sv
// Directed self-checking bench for load_unit with a combinational word memory model.
module tb_load_unit;

    logic        iclk;
    logic        irst;
    logic        ireq_valid;
    logic        oreq_ready;
    logic [7:0]  ireq_addr;
    logic [2:0]  ireq_funct3;
    logic [4:0]  ireq_tag;
    logic [7:0]  omem_addr;
    logic        omem_ren;
    logic [31:0] imem_rdata;
    logic        orsp_valid;
    logic        irsp_ready;
    logic [31:0] orsp_data;
    logic [4:0]  orsp_tag;
    logic        orsp_err;

    logic [31:0] mem [0:63];
    int          n_checks;
    int          n_fail;
    int          cyc;

    load_unit #(
        .MP_DATA_WIDTH (32),
        .MP_ADDR_WIDTH (8),
        .MP_TAG_WIDTH  (5)
    ) dut (
        .iclk        (iclk),
        .irst        (irst),
        .ireq_valid  (ireq_valid),
        .oreq_ready  (oreq_ready),
        .ireq_addr   (ireq_addr),
        .ireq_funct3 (ireq_funct3),
        .ireq_tag    (ireq_tag),
        .omem_addr   (omem_addr),
        .omem_ren    (omem_ren),
        .imem_rdata  (imem_rdata),
        .orsp_valid  (orsp_valid),
        .irsp_ready  (irsp_ready),
        .orsp_data   (orsp_data),
        .orsp_tag    (orsp_tag),
        .orsp_err    (orsp_err)
    );

    assign imem_rdata = mem[omem_addr[7:2]];

    initial iclk = 1'b0;
    always #5 iclk = ~iclk;

    always @(posedge iclk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge iclk);
        #1;
    endtask

    // Offers one request and returns just after the accepting edge.
    task automatic send(input logic [7:0] a, input logic [2:0] f, input logic [4:0] t);
        int n;
        n = 0;
        ireq_valid  = 1'b1;
        ireq_addr   = a;
        ireq_funct3 = f;
        ireq_tag    = t;
        while (!oreq_ready && n < 10) begin
            tick();
            n++;
        end
        if (!oreq_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout oreq_ready=%0b required=1", oreq_ready);
        end
        tick();
        ireq_valid = 1'b0;
    endtask

    task automatic test_reset();
        irst       = 1'b1;
        ireq_valid = 1'b1;
        ireq_addr  = 8'h10;
        irsp_ready = 1'b1;
        tick();
        tick();
        n_checks++;
        if (oreq_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got=%0b exp=0", oreq_ready); end
        n_checks++;
        if ({omem_addr, omem_ren, orsp_valid, orsp_data, orsp_tag, orsp_err} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs got addr=%h ren=%0b v=%0b d=%h t=%0d e=%0b exp=all zero",
                     omem_addr, omem_ren, orsp_valid, orsp_data, orsp_tag, orsp_err);
        end
        irst       = 1'b0;
        ireq_valid = 1'b0;
        #1;
        n_checks++;
        if (oreq_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_ready got=%0b exp=1", oreq_ready); end
        tick();
        n_checks++;
        if (omem_ren !== 1'b0 || orsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_req_dropped got ren=%0b v=%0b exp=0 0", omem_ren, orsp_valid);
        end
    endtask

    task automatic test_byte();
        logic [7:0]  va [3];
        logic [2:0]  vf [3];
        logic [31:0] vd [3];
        va[0] = 8'h10; vf[0] = 3'b000; vd[0] = 32'hFFFF_FFF1;
        va[1] = 8'h10; vf[1] = 3'b100; vd[1] = 32'h0000_00F1;
        va[2] = 8'h13; vf[2] = 3'b000; vd[2] = 32'hFFFF_FF88;
        irsp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            send(va[i], vf[i], 5'(i + 1));
            n_checks++;
            if (omem_addr !== 8'h10 || omem_ren !== 1'b1 || orsp_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL byte_read[%0d] got addr=%h ren=%0b v=%0b exp=10 1 0", i, omem_addr, omem_ren, orsp_valid);
            end
            tick();
            n_checks++;
            if (orsp_valid !== 1'b1 || orsp_data !== vd[i] || orsp_err !== 1'b0 || orsp_tag !== 5'(i + 1)) begin
                n_fail++;
                $display("FAIL byte_rsp[%0d] got v=%0b d=%h e=%0b t=%0d exp=1 %h 0 %0d",
                         i, orsp_valid, orsp_data, orsp_err, orsp_tag, vd[i], i + 1);
            end
            tick();
            n_checks++;
            if (orsp_valid !== 1'b0) begin n_fail++; $display("FAIL byte_retire[%0d] got v=%0b exp=0", i, orsp_valid); end
        end
    endtask

    task automatic test_half();
        logic [7:0]  va [2];
        logic [2:0]  vf [2];
        logic [31:0] vd [2];
        va[0] = 8'h13; vf[0] = 3'b001; vd[0] = 32'hFFFF_F188;
        va[1] = 8'h12; vf[1] = 3'b101; vd[1] = 32'h0000_8844;
        irsp_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            send(va[i], vf[i], 5'(i + 10));
            n_checks++;
            if (omem_addr !== 8'h10) begin n_fail++; $display("FAIL half_addr[%0d] got=%h exp=10", i, omem_addr); end
            tick();
            n_checks++;
            if (orsp_valid !== 1'b1 || orsp_data !== vd[i] || orsp_err !== 1'b0 || orsp_tag !== 5'(i + 10)) begin
                n_fail++;
                $display("FAIL half_rsp[%0d] got v=%0b d=%h e=%0b t=%0d exp=1 %h 0 %0d",
                         i, orsp_valid, orsp_data, orsp_err, orsp_tag, vd[i], i + 10);
            end
            tick();
        end
    endtask

    task automatic test_word_err();
        logic [7:0]  va [3];
        logic [2:0]  vf [3];
        logic [31:0] vd [3];
        logic        ve [3];
        va[0] = 8'h10; vf[0] = 3'b010; vd[0] = 32'h8844_22F1; ve[0] = 1'b0;
`ifdef LOAD_MISALIGN_TRAP_EN
        va[1] = 8'h11; vf[1] = 3'b010; vd[1] = 32'h0000_0000; ve[1] = 1'b1;
`else
        va[1] = 8'h11; vf[1] = 3'b010; vd[1] = 32'hF188_4422; ve[1] = 1'b0;
`endif
        va[2] = 8'h10; vf[2] = 3'b011; vd[2] = 32'h0000_0000; ve[2] = 1'b1;
        irsp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            send(va[i], vf[i], 5'(i + 20));
            n_checks++;
            if (orsp_valid !== 1'b0) begin n_fail++; $display("FAIL word_early[%0d] got v=%0b exp=0", i, orsp_valid); end
            tick();
            n_checks++;
            if (orsp_valid !== 1'b1 || orsp_data !== vd[i] || orsp_err !== ve[i] || orsp_tag !== 5'(i + 20)) begin
                n_fail++;
                $display("FAIL word_rsp[%0d] got v=%0b d=%h e=%0b t=%0d exp=1 %h %0b %0d",
                         i, orsp_valid, orsp_data, orsp_err, orsp_tag, vd[i], ve[i], i + 20);
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        irsp_ready = 1'b0;
        send(8'h10, 3'b000, 5'd7);
        tick();
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (orsp_valid !== 1'b1 || orsp_data !== 32'hFFFF_FFF1 || orsp_tag !== 5'd7 || oreq_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold[%0d] got v=%0b d=%h t=%0d rdy=%0b exp=1 fffffff1 7 0",
                         i, orsp_valid, orsp_data, orsp_tag, oreq_ready);
            end
            tick();
        end
        ireq_valid  = 1'b1;
        ireq_addr   = 8'h13;
        ireq_funct3 = 3'b100;
        ireq_tag    = 5'd9;
        irsp_ready  = 1'b1;
        #1;
        n_checks++;
        if (oreq_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready got=%0b exp=1", oreq_ready); end
        tick();
        ireq_valid = 1'b0;
        n_checks++;
        if (orsp_valid !== 1'b0 || omem_ren !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_retire got v=%0b ren=%0b exp=0 1", orsp_valid, omem_ren);
        end
        tick();
        n_checks++;
        if (orsp_valid !== 1'b1 || orsp_data !== 32'h0000_0088 || orsp_tag !== 5'd9) begin
            n_fail++;
            $display("FAIL bp_next_rsp got v=%0b d=%h t=%0d exp=1 00000088 9", orsp_valid, orsp_data, orsp_tag);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [7:0]  va [4];
        logic [2:0]  vf [4];
        logic [31:0] vd [4];
        int          last;
        va[0] = 8'h20; vf[0] = 3'b010; vd[0] = 32'hA0A1_A2A3;
        va[1] = 8'h26; vf[1] = 3'b101; vd[1] = 32'h0000_0BAD;
        va[2] = 8'h29; vf[2] = 3'b000; vd[2] = 32'hFFFF_FFBE;
        va[3] = 8'h2C; vf[3] = 3'b010; vd[3] = 32'h1234_5678;
        last = 0;
        irsp_ready = 1'b1;
        send(va[0], vf[0], 5'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++;
            if (orsp_valid !== 1'b1 || orsp_data !== vd[i] || orsp_tag !== 5'(i + 1)) begin
                n_fail++;
                $display("FAIL b2b_rsp[%0d] got v=%0b d=%h t=%0d exp=1 %h %0d",
                         i, orsp_valid, orsp_data, orsp_tag, vd[i], i + 1);
            end
            if (i > 0) begin
                n_checks++;
                if (cyc - last !== 2) begin n_fail++; $display("FAIL b2b_spacing[%0d] got=%0d exp=2", i, cyc - last); end
            end
            last = cyc;
            if (i < 3) begin
                ireq_valid  = 1'b1;
                ireq_addr   = va[i + 1];
                ireq_funct3 = vf[i + 1];
                ireq_tag    = 5'(i + 2);
                #1;
                n_checks++;
                if (oreq_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready[%0d] got=%0b exp=1", i, oreq_ready); end
            end
            tick();
            ireq_valid = 1'b0;
        end
    endtask

    task automatic test_reset_mid();
        irsp_ready = 1'b1;
        send(8'h10, 3'b010, 5'd3);
        irst = 1'b1;
        tick();
        n_checks++;
        if (orsp_valid !== 1'b0 || oreq_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_read got v=%0b rdy=%0b exp=0 0", orsp_valid, oreq_ready);
        end
        irst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (orsp_valid !== 1'b0 || oreq_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL rst_read_after[%0d] got v=%0b rdy=%0b exp=0 1", i, orsp_valid, oreq_ready);
            end
        end
        send(8'h10, 3'b010, 5'd4);
        tick();
        n_checks++;
        if (orsp_valid !== 1'b1) begin n_fail++; $display("FAIL rst_resp_pre got v=%0b exp=1", orsp_valid); end
        irsp_ready = 1'b0;
        irst       = 1'b1;
        tick();
        n_checks++;
        if (orsp_valid !== 1'b0 || oreq_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_resp got v=%0b rdy=%0b exp=0 0", orsp_valid, oreq_ready);
        end
        irst       = 1'b0;
        irsp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (orsp_valid !== 1'b0 || oreq_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL rst_resp_after[%0d] got v=%0b rdy=%0b exp=0 1", i, orsp_valid, oreq_ready);
            end
        end
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        cyc         = 0;
        irst        = 1'b1;
        ireq_valid  = 1'b0;
        ireq_addr   = '0;
        ireq_funct3 = '0;
        ireq_tag    = '0;
        irsp_ready  = 1'b0;
        for (int i = 0; i < 64; i++) mem[i] = 32'h5A5A_0000 | 32'(i);
        mem[4]  = 32'h8844_22F1;
        mem[8]  = 32'hA0A1_A2A3;
        mem[9]  = 32'h0BAD_F00D;
        mem[10] = 32'hDEAD_BEEF;
        mem[11] = 32'h1234_5678;

        test_reset();
        test_byte();
        test_half();
        test_word_err();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
